// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with tree-PLRU replacement and a post-reset
// invalidation sweep. Define BTB_ASSOC_BYPASS_EN to forward same-cycle updates to lookups.
module btb_assoc #(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned SETS    = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned VADDR_W = 32,
  localparam int unsigned IDX_W  = $clog2(SETS),
  localparam int unsigned WAY_W  = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               lkp_valid,
  input  logic [VADDR_W-1:0] lkp_pc,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way,
  output logic [VADDR_W-1:0] resp_target,
  output logic [1:0]         resp_type,
  input  logic               upd_valid,
  input  logic [VADDR_W-1:0] upd_pc,
  input  logic [VADDR_W-1:0] upd_target,
  input  logic [1:0]         upd_type,
  input  logic               upd_inval,
  output logic               init_done
);

  typedef enum logic {StInit, StReady} state_e;
  typedef logic [WAYS-2:0] plru_t;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [VADDR_W-1:0] tgt_q   [SETS][WAYS];
  logic [1:0]         type_q  [SETS][WAYS];
  plru_t              plru_q  [SETS];

  function automatic logic [TAG_W-1:0] tag_of(input logic [VADDR_W-1:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2] ^ pc[IDX_W+2*TAG_W+1:IDX_W+TAG_W+2];
  endfunction

  // Heap-ordered tree: node n (root = 1) lives at bit n-1; 0 sends the victim left.
  function automatic plru_t plru_touch(input plru_t cur, input logic [WAY_W-1:0] way);
    plru_t            nxt;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] w;
    logic             b;
    nxt  = cur;
    node = WAY_W'(1);
    w    = way;
    for (int l = 0; l < int'(WAY_W); l++) begin
      b                       = w[WAY_W-1];
      nxt[node - WAY_W'(1)]   = ~b;
      node                    = (node << 1) | WAY_W'(b);
      w                       = w << 1;
    end
    return nxt;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input plru_t cur);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] v;
    logic             b;
    node = WAY_W'(1);
    v    = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      b    = cur[node - WAY_W'(1)];
      v    = (v << 1) | WAY_W'(b);
      node = (node << 1) | WAY_W'(b);
    end
    return v;
  endfunction

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             ready;
  logic             lkp_hit, upd_hit, inv_any;
  logic [WAY_W-1:0] lkp_way, upd_hit_way, inv_way, upd_way;
  logic             lkp_touch, upd_write, upd_clear;
  plru_t            plru_lkp, plru_base, plru_upd;
  logic             unused_pc;

  assign lkp_idx   = lkp_pc[IDX_W+1:2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign lkp_tag   = tag_of(lkp_pc);
  assign upd_tag   = tag_of(upd_pc);
  assign ready     = (state_q == StReady);
  assign unused_pc = ^{lkp_pc, upd_pc};

  always_comb begin
    lkp_hit     = 1'b0;
    lkp_way     = '0;
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    inv_any     = 1'b0;
    inv_way     = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!lkp_hit && valid_q[lkp_idx][w] && (tag_q[lkp_idx][w] == lkp_tag)) begin
        lkp_hit = 1'b1;
        lkp_way = WAY_W'(w);
      end
      if (!upd_hit && valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!inv_any && !valid_q[upd_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign upd_way   = upd_hit ? upd_hit_way : (inv_any ? inv_way : plru_victim(plru_q[upd_idx]));
  assign lkp_touch = lkp_valid & ~stall & ready & lkp_hit;
  assign upd_write = upd_valid & ready & ~upd_inval;
  assign upd_clear = upd_valid & ready & upd_inval & upd_hit;

  // The update touch is applied on top of a same-set lookup touch so it lands last.
  assign plru_lkp  = plru_touch(plru_q[lkp_idx], lkp_way);
  assign plru_base = (lkp_touch && (lkp_idx == upd_idx)) ? plru_lkp : plru_q[upd_idx];
  assign plru_upd  = plru_touch(plru_base, upd_way);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else if (state_q == StInit) begin
      cnt_q <= cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(SETS - 1)) begin
        state_q   <= StReady;
        init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      if (lkp_touch) plru_q[lkp_idx] <= plru_lkp;
      if (upd_write) plru_q[upd_idx] <= plru_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      valid_q[cnt_q] <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx][upd_way] <= 1'b1;
      tag_q[upd_idx][upd_way]   <= upd_tag;
      tgt_q[upd_idx][upd_way]   <= upd_target;
      type_q[upd_idx][upd_way]  <= upd_type;
    end else if (upd_clear) begin
      valid_q[upd_idx][upd_hit_way] <= 1'b0;
    end
  end

  logic               rsp_hit;
  logic [WAY_W-1:0]   rsp_way;
  logic [VADDR_W-1:0] rsp_tgt;
  logic [1:0]         rsp_type;

  always_comb begin
    rsp_hit  = 1'b0;
    rsp_way  = '0;
    rsp_tgt  = '0;
    rsp_type = '0;
    if (ready && lkp_hit) begin
      rsp_hit  = 1'b1;
      rsp_way  = lkp_way;
      rsp_tgt  = tgt_q[lkp_idx][lkp_way];
      rsp_type = type_q[lkp_idx][lkp_way];
    end
`ifdef BTB_ASSOC_BYPASS_EN
    if (ready && upd_valid && (upd_idx == lkp_idx) && (upd_tag == lkp_tag)) begin
      rsp_hit  = ~upd_inval;
      rsp_way  = upd_inval ? '0 : upd_way;
      rsp_tgt  = upd_inval ? '0 : upd_target;
      rsp_type = upd_inval ? '0 : upd_type;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_target <= '0;
      resp_type   <= '0;
    end else if (!stall) begin
      resp_valid  <= lkp_valid;
      resp_hit    <= lkp_valid & rsp_hit;
      resp_way    <= lkp_valid ? rsp_way : '0;
      resp_target <= lkp_valid ? rsp_tgt : '0;
      resp_type   <= lkp_valid ? rsp_type : '0;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Randomised bench for btb_assoc against a timestamp-based behavioural model of the table.
module tb_btb_assoc;
  localparam int unsigned WAYS    = 4;
  localparam int unsigned SETS    = 64;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned VADDR_W = 32;
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned WAY_W   = $clog2(WAYS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, lkp_valid = 1'b0, upd_valid = 1'b0, upd_inval = 1'b0;
  logic [VADDR_W-1:0] lkp_pc = '0, upd_pc = '0, upd_target = '0;
  logic [1:0] upd_type = '0;
  logic resp_valid, resp_hit, init_done;
  logic [WAY_W-1:0] resp_way;
  logic [VADDR_W-1:0] resp_target;
  logic [1:0] resp_type;

  int n_checks = 0;
  int n_fail = 0;

  btb_assoc #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .VADDR_W(VADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_target(resp_target), .resp_type(resp_type), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_type(upd_type),
    .upd_inval(upd_inval), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: per-entry state plus a last-touch timestamp per way.
  bit          m_ready;
  int          m_cnt;
  bit          m_v    [SETS][WAYS];
  int          m_tg   [SETS][WAYS];
  logic [31:0] m_tgt  [SETS][WAYS];
  logic [1:0]  m_type [SETS][WAYS];
  int unsigned m_ts   [SETS][WAYS];
  int unsigned m_now;
  logic        e_valid, e_hit;
  logic [1:0]  e_way, e_type;
  logic [31:0] e_tgt;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int m_tag(input logic [31:0] pc);
    return int'(((pc >> (IDX_W + 2)) ^ (pc >> (IDX_W + TAG_W + 2))) % (1 << TAG_W));
  endfunction

  function automatic logic [31:0] mk_pc(input int idx, input int lo, input int hi, input int up);
    logic [31:0] pc;
    pc = (32'(up) << (IDX_W + 2*TAG_W + 2)) | (32'(hi) << (IDX_W + TAG_W + 2)) |
         (32'(lo) << (IDX_W + 2)) | (32'(idx) << 2);
    return pc;
  endfunction

  function automatic logic [31:0] rand_pc();
    return mk_pc(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 255))) |
           32'($urandom_range(0, 3));
  endfunction

  task automatic m_find(input int s, input int t, output bit h, output int w);
    h = 0;
    w = 0;
    for (int i = 0; i < WAYS; i++)
      if (!h && m_v[s][i] && m_tg[s][i] == t) begin
        h = 1;
        w = i;
      end
  endtask

  // Victim: descend into whichever half was touched less recently (left on a tie).
  function automatic int m_victim(input int s);
    int lo, size;
    lo = 0;
    size = WAYS;
    while (size > 1) begin
      int half;
      int unsigned ml, mr;
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int w = lo; w < lo + half; w++) if (m_ts[s][w] > ml) ml = m_ts[s][w];
      for (int w = lo + half; w < lo + size; w++) if (m_ts[s][w] > mr) mr = m_ts[s][w];
      if (ml > mr) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    m_now++;
    m_ts[s][w] = m_now;
  endtask

  task automatic m_reset();
    m_ready = 0;
    m_cnt = 0;
    m_now = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0;
        m_ts[s][w] = 0;
      end
    e_valid = 0; e_hit = 0; e_way = 0; e_tgt = 0; e_type = 0;
  endtask

  task automatic cycle();
    int li, ui, lw, uw, ww, lt, ut;
    bit lh, uh;
    li = m_idx(lkp_pc); lt = m_tag(lkp_pc); m_find(li, lt, lh, lw);
    ui = m_idx(upd_pc); ut = m_tag(upd_pc); m_find(ui, ut, uh, uw);
    ww = uw;
    if (!uh) begin
      ww = -1;
      for (int w = 0; w < WAYS; w++) if (ww < 0 && !m_v[ui][w]) ww = w;
      if (ww < 0) ww = m_victim(ui);
    end
    if (!stall) begin
      e_valid = lkp_valid; e_hit = 0; e_way = 0; e_tgt = 0; e_type = 0;
      if (lkp_valid && m_ready && lh) begin
        e_hit = 1; e_way = 2'(lw); e_tgt = m_tgt[li][lw]; e_type = m_type[li][lw];
        m_touch(li, lw);
      end
`ifdef BTB_ASSOC_BYPASS_EN
      if (lkp_valid && m_ready && upd_valid && ui == li && ut == lt) begin
        if (upd_inval) begin
          e_hit = 0; e_way = 0; e_tgt = 0; e_type = 0;
        end else begin
          e_hit = 1; e_way = 2'(ww); e_tgt = upd_target; e_type = upd_type;
        end
      end
`endif
    end
    if (m_ready && upd_valid) begin
      if (upd_inval) begin
        if (uh) m_v[ui][uw] = 0;
      end else begin
        m_v[ui][ww] = 1; m_tg[ui][ww] = ut; m_tgt[ui][ww] = upd_target;
        m_type[ui][ww] = upd_type;
        m_touch(ui, ww);
      end
    end
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == SETS) m_ready = 1;
    end
    @(posedge clk);
    #1;
    check("resp_valid", 64'(resp_valid), 64'(e_valid));
    check("resp_hit", 64'(resp_hit), 64'(e_hit));
    check("resp_way", 64'(resp_way), 64'(e_way));
    check("resp_target", 64'(resp_target), 64'(e_tgt));
    check("resp_type", 64'(resp_type), 64'(e_type));
    check("init_done", 64'(init_done), 64'(m_ready));
  endtask

  task automatic idle();
    stall = 0; lkp_valid = 0; upd_valid = 0; upd_inval = 0;
  endtask

  task automatic apply_reset(input int hold);
    rst = 1;
    #2;
    m_reset();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_hit", 64'(resp_hit), 64'd0);
    check("rst_resp_target", 64'(resp_target), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Lookups throughout the sweep; stops when init_done rises or after max cycles.
  task automatic run_init(input int max, output int n);
    n = 0;
    while (!init_done && n < max) begin
      idle();
      lkp_valid = 1;
      lkp_pc = rand_pc();
      upd_valid = 1;
      upd_pc = lkp_pc;
      upd_target = $urandom();
      cycle();
      n++;
      check("init_lookup_miss", 64'(resp_hit), 64'd0);
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      stall = ($urandom_range(0, 7) == 0);
      lkp_valid = ($urandom_range(0, 3) != 0);
      lkp_pc = rand_pc();
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_inval = ($urandom_range(0, 5) == 0);
      upd_pc = ($urandom_range(0, 3) == 0) ? lkp_pc : rand_pc();
      upd_target = $urandom();
      upd_type = 2'($urandom_range(0, 3));
      cycle();
    end
    idle();
  endtask

  initial begin
    int n;
    apply_reset(2);
    run_init(200, n);
    check("init_latency", 64'(n), 64'(SETS));

    // Update then lookup of 0x1000.
    idle();
    upd_valid = 1; upd_pc = 32'h1000; upd_target = 32'h2000; upd_type = 2'd1;
    cycle();
    idle();
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
    check("upd_lkp_hit", 64'(resp_hit), 64'd1);
    check("upd_lkp_target", 64'(resp_target), 64'h2000);
    check("upd_lkp_type", 64'(resp_type), 64'd1);
    check("upd_lkp_way", 64'(resp_way), 64'd0);

    // Invalidate, then lookup misses.
    idle();
    upd_valid = 1; upd_inval = 1; upd_pc = 32'h1000;
    cycle();
    idle();
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
    check("inval_miss", 64'(resp_hit), 64'd0);

    // Same-cycle update and lookup of one address.
    idle();
    upd_valid = 1; upd_pc = 32'h1000; upd_target = 32'h3000; upd_type = 2'd2;
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
`ifdef BTB_ASSOC_BYPASS_EN
    check("same_cycle_hit", 64'(resp_hit), 64'd1);
    check("same_cycle_target", 64'(resp_target), 64'h3000);
`else
    check("same_cycle_hit", 64'(resp_hit), 64'd0);
`endif
    idle();
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
    check("after_write_target", 64'(resp_target), 64'h3000);

    // Fill set 5, touch ways 2,0,1, fifth tag must evict way 3.
    idle();
    for (int t = 1; t <= 4; t++) begin
      upd_valid = 1; upd_pc = mk_pc(5, t, 0, 0); upd_target = 32'(t * 256);
      upd_type = 2'(t);
      cycle();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      int t;
      t = (k == 0) ? 3 : k;
      lkp_valid = 1; lkp_pc = mk_pc(5, t, 0, 0);
      cycle();
      check("plru_touch_way", 64'(resp_way), 64'(t - 1));
    end
    idle();
    upd_valid = 1; upd_pc = mk_pc(5, 5, 0, 0); upd_target = 32'h5555;
    cycle();
    idle();
    lkp_valid = 1; lkp_pc = mk_pc(5, 4, 0, 0);
    cycle();
    check("evicted_tag_miss", 64'(resp_hit), 64'd0);
    lkp_pc = mk_pc(5, 5, 0, 0);
    cycle();
    check("new_tag_hit", 64'(resp_hit), 64'd1);
    check("new_tag_way", 64'(resp_way), 64'd3);

    // Stall holds the response while lkp_pc changes.
    idle();
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
    for (int k = 0; k < 3; k++) begin
      stall = 1;
      lkp_pc = mk_pc(5, k + 1, 0, 0);
      cycle();
      check("stall_hold_hit", 64'(resp_hit), 64'd1);
      check("stall_hold_target", 64'(resp_target), 64'h3000);
    end
    idle();
    cycle();
    check("idle_resp_valid", 64'(resp_valid), 64'd0);

    random_run(1500);

    // Reset mid-operation restarts the sweep and empties the table.
    apply_reset(1);
    run_init(200, n);
    check("reinit_latency", 64'(n), 64'(SETS));
    idle();
    lkp_valid = 1; lkp_pc = 32'h1000;
    cycle();
    check("reinit_empty", 64'(resp_hit), 64'd0);
    random_run(300);

    // Reset at sweep count 30: a full sweep follows.
    apply_reset(1);
    run_init(30, n);
    check("mid_init_not_done", 64'(init_done), 64'd0);
    apply_reset(1);
    run_init(200, n);
    check("mid_init_restart", 64'(n), 64'(SETS));
    random_run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
